// File: rtl/fetch_pc_predictor.sv
// Front-end next-PC generator with a direct-mapped BTB and 2-bit counters.
// Execute-stage resolutions redirect fetch, flush younger work and train the BTB.
module fetch_pc_predictor #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BTB_IDX_W = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        stall_i,
   output logic [31:0] pc_o,
   output logic [31:0] pred_next_o,
   output logic        pred_taken_o,
   input  logic        resolve_valid_i,
   input  logic        resolve_jump_i,
   input  logic [31:0] resolve_addr_i,
   input  logic [31:0] resolve_target_i,
   input  logic [31:0] resolve_next_addr_i,
   output logic        flush_o,
   output logic        misalign_o,
   output logic [31:0] stat_jumps_o,
   output logic [31:0] stat_mispredicts_o
);

   localparam int N     = 1 << BTB_IDX_W;
   localparam int TAG_W = 30 - BTB_IDX_W;

   logic             btb_valid [N];
   logic [TAG_W-1:0] btb_tag   [N];
   logic [29:0]      btb_tgt   [N];
   logic [1:0]       btb_ctr   [N];

   logic [BTB_IDX_W-1:0] look_idx;
   logic [BTB_IDX_W-1:0] res_idx;
   logic [TAG_W-1:0]     look_tag;
   logic [TAG_W-1:0]     res_tag;
   logic                 look_hit;
   logic                 res_hit;
   logic [31:0]          seq_pc;
   logic [31:0]          res_seq;
   logic                 res;
   logic                 taken;
   logic                 mis;
   logic                 bad;
   logic                 redirect;
   logic                 train;
   logic [1:0]           res_ctr;

   // Lookup reads the flops directly, so a same-cycle update is not visible
   assign look_idx     = pc_o[BTB_IDX_W+1:2];
   assign look_tag     = pc_o[31:BTB_IDX_W+2];
   assign look_hit     = btb_valid[look_idx] &&
                         (btb_tag[look_idx] == look_tag);
   assign pred_taken_o = look_hit && btb_ctr[look_idx][1];
   assign seq_pc       = pc_o + 32'd4;
   assign pred_next_o  = pred_taken_o ? {btb_tgt[look_idx], 2'b00}
                                      : seq_pc;

   assign res_idx  = resolve_addr_i[BTB_IDX_W+1:2];
   assign res_tag  = resolve_addr_i[31:BTB_IDX_W+2];
   assign res_hit  = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
   assign res_ctr  = btb_ctr[res_idx];
   assign res_seq  = resolve_addr_i + 32'd4;
   assign res      = resolve_valid_i && resolve_jump_i;
   assign taken    = resolve_target_i != res_seq;
   assign mis      = res && (resolve_target_i != resolve_next_addr_i);
   assign bad      = res && (resolve_target_i[1:0] != 2'b00);
   assign redirect = mis && !bad;
   assign train    = res && !bad;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         pc_o               <= RESET_PC;
         flush_o            <= 1'b0;
         misalign_o         <= 1'b0;
         stat_jumps_o       <= 32'd0;
         stat_mispredicts_o <= 32'd0;
         for (int i = 0; i < N; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= 2'b00;
         end
      end else begin
         flush_o    <= redirect;
         misalign_o <= bad;

         if (redirect) begin
            pc_o <= resolve_target_i;
         end else if (!stall_i) begin
            pc_o <= pred_next_o;
         end

         if (res) begin
            stat_jumps_o <= stat_jumps_o + 32'd1;
         end
         if (redirect) begin
            stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
         end

         if (train) begin
            unique case (1'b1)
               res_hit && taken: begin
                  btb_tgt[res_idx] <= resolve_target_i[31:2];
                  if (res_ctr != 2'b11) begin
                     btb_ctr[res_idx] <= res_ctr + 2'b01;
                  end
               end
               res_hit && !taken: begin
                  if (res_ctr != 2'b00) begin
                     btb_ctr[res_idx] <= res_ctr - 2'b01;
                  end
               end
               !res_hit && taken: begin
                  btb_valid[res_idx] <= 1'b1;
                  btb_tag[res_idx]   <= res_tag;
                  btb_tgt[res_idx]   <= resolve_target_i[31:2];
                  btb_ctr[res_idx]   <= 2'b10;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed scenarios plus a randomized run
// checked against a behavioural next-PC / BTB model.
module tb_fetch_pc_predictor;

   localparam int NE = 16;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic [31:0] pred_next_o;
   logic        pred_taken_o;
   logic        resolve_valid_i;
   logic        resolve_jump_i;
   logic [31:0] resolve_addr_i;
   logic [31:0] resolve_target_i;
   logic [31:0] resolve_next_addr_i;
   logic        flush_o;
   logic        misalign_o;
   logic [31:0] stat_jumps_o;
   logic [31:0] stat_mispredicts_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   fetch_pc_predictor #(
      .RESET_PC  (32'h0000_0000),
      .BTB_IDX_W (4)
   ) dut (
      .clock_i             (clk),
      .reset_i             (reset_i),
      .stall_i             (stall_i),
      .pc_o                (pc_o),
      .pred_next_o         (pred_next_o),
      .pred_taken_o        (pred_taken_o),
      .resolve_valid_i     (resolve_valid_i),
      .resolve_jump_i      (resolve_jump_i),
      .resolve_addr_i      (resolve_addr_i),
      .resolve_target_i    (resolve_target_i),
      .resolve_next_addr_i (resolve_next_addr_i),
      .flush_o             (flush_o),
      .misalign_o          (misalign_o),
      .stat_jumps_o        (stat_jumps_o),
      .stat_mispredicts_o  (stat_mispredicts_o)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_res();
      resolve_valid_i     = 1'b0;
      resolve_jump_i      = 1'b0;
      resolve_addr_i      = 32'd0;
      resolve_target_i    = 32'd0;
      resolve_next_addr_i = 32'd0;
   endtask

   task automatic drive_res(input logic [31:0] a, input logic [31:0] t,
                            input logic [31:0] n);
      resolve_valid_i     = 1'b1;
      resolve_jump_i      = 1'b1;
      resolve_addr_i      = a;
      resolve_target_i    = t;
      resolve_next_addr_i = n;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      stall_i = 1'b0;
      clear_res();
      repeat (2) step();
      total++;
      if (pc_o !== 32'h0 || pred_taken_o !== 1'b0 || pred_next_o !== 32'h4) begin
         bad++;
         $display("FAIL reset_pred pc=%h taken=%b next=%h want 0/0/4",
                  pc_o, pred_taken_o, pred_next_o);
      end
      total++;
      if (flush_o !== 1'b0 || misalign_o !== 1'b0 ||
          stat_jumps_o !== 32'd0 || stat_mispredicts_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_flags flush=%b mal=%b j=%0d m=%0d want 0",
                  flush_o, misalign_o, stat_jumps_o, stat_mispredicts_o);
      end
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (pc_o !== 32'(i * 4) || pred_taken_o !== 1'b0 || flush_o !== 1'b0) begin
            bad++;
            $display("FAIL seq_fetch pc=%h taken=%b flush=%b want pc=%h",
                     pc_o, pred_taken_o, flush_o, 32'(i * 4));
         end
         step();
      end
   endtask

   task automatic test_mispredict();
      drive_res(32'h10, 32'h40, 32'h14);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h40 || flush_o !== 1'b1 ||
          stat_mispredicts_o !== 32'd1 || stat_jumps_o !== 32'd1) begin
         bad++;
         $display("FAIL mis_redirect pc=%h flush=%b m=%0d j=%0d want 40/1/1/1",
                  pc_o, flush_o, stat_mispredicts_o, stat_jumps_o);
      end
      total++;
      if (dut.btb_valid[4] !== 1'b1 || dut.btb_ctr[4] !== 2'd2) begin
         bad++;
         $display("FAIL mis_alloc valid=%b ctr=%0d want 1/2",
                  dut.btb_valid[4], dut.btb_ctr[4]);
      end
      step();
      total++;
      if (flush_o !== 1'b0 || pc_o !== 32'h44) begin
         bad++;
         $display("FAIL mis_pulse flush=%b pc=%h want 0/44", flush_o, pc_o);
      end
   endtask

   task automatic test_train_taken();
      drive_res(32'h200, 32'h10, 32'h204);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h10 || pred_taken_o !== 1'b1 ||
          pred_next_o !== 32'h40 || flush_o !== 1'b1) begin
         bad++;
         $display("FAIL hit_pred pc=%h taken=%b next=%h flush=%b want 10/1/40/1",
                  pc_o, pred_taken_o, pred_next_o, flush_o);
      end
      drive_res(32'h10, 32'h40, 32'h40);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h40 || flush_o !== 1'b0 || dut.btb_ctr[4] !== 2'd3 ||
          stat_jumps_o !== 32'd3 || stat_mispredicts_o !== 32'd2) begin
         bad++;
         $display("FAIL taken_train pc=%h flush=%b ctr=%0d j=%0d m=%0d want 40/0/3/3/2",
                  pc_o, flush_o, dut.btb_ctr[4], stat_jumps_o, stat_mispredicts_o);
      end
   endtask

   task automatic test_train_not_taken();
      drive_res(32'h10, 32'h14, 32'h40);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h14 || flush_o !== 1'b1 || dut.btb_ctr[4] !== 2'd2) begin
         bad++;
         $display("FAIL nt_first pc=%h flush=%b ctr=%0d want 14/1/2",
                  pc_o, flush_o, dut.btb_ctr[4]);
      end
      drive_res(32'h10, 32'h14, 32'h14);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h18 || flush_o !== 1'b0 || dut.btb_ctr[4] !== 2'd1) begin
         bad++;
         $display("FAIL nt_second pc=%h flush=%b ctr=%0d want 18/0/1",
                  pc_o, flush_o, dut.btb_ctr[4]);
      end
      drive_res(32'h200, 32'h10, 32'h204);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h10 || pred_taken_o !== 1'b0 || pred_next_o !== 32'h14 ||
          stat_jumps_o !== 32'd6 || stat_mispredicts_o !== 32'd4) begin
         bad++;
         $display("FAIL nt_pred pc=%h taken=%b next=%h j=%0d m=%0d want 10/0/14/6/4",
                  pc_o, pred_taken_o, pred_next_o, stat_jumps_o, stat_mispredicts_o);
      end
   endtask

   task automatic test_stall_redirect();
      drive_res(32'h300, 32'h8, 32'h304);
      step();
      clear_res();
      stall_i = 1'b1;
      step();
      total++;
      if (pc_o !== 32'h8) begin
         bad++;
         $display("FAIL stall_hold pc=%h want 8", pc_o);
      end
      drive_res(32'h400, 32'h100, 32'h404);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'h100 || flush_o !== 1'b1) begin
         bad++;
         $display("FAIL stall_redirect pc=%h flush=%b want 100/1", pc_o, flush_o);
      end
      step();
      total++;
      if (pc_o !== 32'h100 || flush_o !== 1'b0) begin
         bad++;
         $display("FAIL stall_after pc=%h flush=%b want 100/0", pc_o, flush_o);
      end
      stall_i = 1'b0;
      drive_res(32'h500, 32'hFFFF_FFFC, 32'h504);
      step();
      clear_res();
      total++;
      if (pc_o !== 32'hFFFF_FFFC || pred_next_o !== 32'h0) begin
         bad++;
         $display("FAIL wrap_pred pc=%h next=%h want fffffffc/0", pc_o, pred_next_o);
      end
      step();
      total++;
      if (pc_o !== 32'h0 || stat_jumps_o !== 32'd9 || stat_mispredicts_o !== 32'd7) begin
         bad++;
         $display("FAIL wrap_pc pc=%h j=%0d m=%0d want 0/9/7",
                  pc_o, stat_jumps_o, stat_mispredicts_o);
      end
   endtask

   task automatic test_misalign();
      drive_res(32'h100, 32'h42, 32'h104);
      step();
      clear_res();
      total++;
      if (misalign_o !== 1'b1 || flush_o !== 1'b0 || pc_o !== 32'h4 ||
          stat_jumps_o !== 32'd10 || stat_mispredicts_o !== 32'd7) begin
         bad++;
         $display("FAIL misalign mal=%b flush=%b pc=%h j=%0d m=%0d want 1/0/4/10/7",
                  misalign_o, flush_o, pc_o, stat_jumps_o, stat_mispredicts_o);
      end
      total++;
      if (dut.btb_tag[0] !== 26'(32'h500 >> 6) ||
          dut.btb_tgt[0] !== 30'(32'hFFFF_FFFC >> 2) || dut.btb_ctr[0] !== 2'd2) begin
         bad++;
         $display("FAIL misalign_btb tag=%h tgt=%h ctr=%0d want 14/3fffffff/2",
                  dut.btb_tag[0], dut.btb_tgt[0], dut.btb_ctr[0]);
      end
      step();
      total++;
      if (misalign_o !== 1'b0) begin
         bad++;
         $display("FAIL misalign_pulse mal=%b want 0", misalign_o);
      end
   endtask

   task automatic test_reset_mid_flush();
      drive_res(32'h10, 32'h80, 32'h14);
      step();
      clear_res();
      total++;
      if (flush_o !== 1'b1 || pc_o !== 32'h80) begin
         bad++;
         $display("FAIL pre_reset flush=%b pc=%h want 1/80", flush_o, pc_o);
      end
      reset_i = 1'b1;
      drive_res(32'h20, 32'h60, 32'h24);
      step();
      clear_res();
      reset_i = 1'b0;
      total++;
      if (pc_o !== 32'h0 || flush_o !== 1'b0 || misalign_o !== 1'b0 ||
          stat_jumps_o !== 32'd0 || stat_mispredicts_o !== 32'd0) begin
         bad++;
         $display("FAIL mid_reset pc=%h flush=%b mal=%b j=%0d m=%0d want 0",
                  pc_o, flush_o, misalign_o, stat_jumps_o, stat_mispredicts_o);
      end
      total++;
      if (dut.btb_valid[4] !== 1'b0 || dut.btb_ctr[4] !== 2'd0 ||
          pred_taken_o !== 1'b0 || pred_next_o !== 32'h4) begin
         bad++;
         $display("FAIL mid_reset_btb valid=%b ctr=%0d taken=%b next=%h want 0/0/0/4",
                  dut.btb_valid[4], dut.btb_ctr[4], pred_taken_o, pred_next_o);
      end
   endtask

   // Behavioural model: per-entry fields kept as plain integers
   bit          m_valid [NE];
   logic [31:0] m_tag   [NE];
   logic [31:0] m_tgt   [NE];
   int          m_ctr   [NE];
   logic [31:0] m_pc;
   bit          m_flush;
   bit          m_mal;
   logic [31:0] m_jumps;
   logic [31:0] m_mis;

   task automatic model_reset();
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 0;
      end
      m_pc    = 32'h0;
      m_flush = 0;
      m_mal   = 0;
      m_jumps = 0;
      m_mis   = 0;
   endtask

   task automatic test_random();
      int          idx;
      bit          hit;
      bit          p_taken;
      logic [31:0] p_next;
      bit          r;
      bit          tk;
      bit          mi;
      bit          bd;
      int          sel;
      logic [31:0] a;
      logic [31:0] t;
      logic [31:0] n;
      reset_i = 1'b1;
      stall_i = 1'b0;
      clear_res();
      step();
      reset_i = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idx     = int'((m_pc / 4) % NE);
         hit     = m_valid[idx] && (m_tag[idx] == m_pc / 64);
         p_taken = hit && (m_ctr[idx] >= 2);
         p_next  = p_taken ? m_tgt[idx] : m_pc + 32'd4;
         total++;
         if (pc_o !== m_pc || pred_taken_o !== p_taken || pred_next_o !== p_next ||
             flush_o !== m_flush || misalign_o !== m_mal ||
             stat_jumps_o !== m_jumps || stat_mispredicts_o !== m_mis) begin
            bad++;
            $display("FAIL rand cyc=%0d pc=%h/%h tk=%b/%b nx=%h/%h fl=%b/%b ma=%b/%b j=%0d/%0d m=%0d/%0d",
                     cyc, pc_o, m_pc, pred_taken_o, p_taken, pred_next_o, p_next,
                     flush_o, m_flush, misalign_o, m_mal,
                     stat_jumps_o, m_jumps, stat_mispredicts_o, m_mis);
         end

         reset_i = ($urandom_range(0, 199) == 0);
         stall_i = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) a = m_pc;
         else a = ($urandom_range(0, 31) * 4) + (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
         sel = int'($urandom_range(0, 9));
         if (sel < 4) t = a + 32'd4;
         else if (sel < 9) t = $urandom_range(0, 255) * 4;
         else t = ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
         sel = int'($urandom_range(0, 3));
         if (sel < 2) n = t;
         else if (sel == 2) n = a + 32'd4;
         else n = $urandom_range(0, 255) * 4;
         resolve_valid_i     = $urandom_range(0, 1);
         resolve_jump_i      = ($urandom_range(0, 4) != 0);
         resolve_addr_i      = a;
         resolve_target_i    = t;
         resolve_next_addr_i = n;

         if (reset_i) begin
            model_reset();
         end else begin
            r  = resolve_valid_i && resolve_jump_i;
            tk = (t != a + 32'd4);
            mi = r && (t != n);
            bd = r && (t % 4 != 0);
            m_flush = mi && !bd;
            m_mal   = bd;
            if (r) m_jumps = m_jumps + 1;
            if (m_flush) m_mis = m_mis + 1;
            if (r && !bd) begin
               idx = int'((a / 4) % NE);
               hit = m_valid[idx] && (m_tag[idx] == a / 64);
               if (hit && tk) begin
                  m_tgt[idx] = t;
                  m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
               end else if (hit) begin
                  m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
               end else if (tk) begin
                  m_valid[idx] = 1;
                  m_tag[idx]   = a / 64;
                  m_tgt[idx]   = t;
                  m_ctr[idx]   = 2;
               end
            end
            if (m_flush) m_pc = t;
            else if (!stall_i) m_pc = p_next;
         end
         step();
      end
      reset_i = 1'b0;
      stall_i = 1'b0;
      clear_res();
   endtask

   initial begin
      test_reset();
      test_mispredict();
      test_train_taken();
      test_train_not_taken();
      test_stall_redirect();
      test_misalign();
      test_reset_mid_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
